// File: rtl/ccx_ic_arbiter_if.sv
// core_mem_bus: single-outstanding request/grant memory bus; rdata/err follow a transfer by one cycle.
// master drives the request side, slave answers with gnt and the delayed response.
interface core_mem_bus #(
    parameter int AW = 39,
    parameter int DW = 64
);
    logic              req;
    logic              gnt;
    logic [AW-1:0]     addr;
    logic              wen;
    logic [DW/8-1:0]   strb;
    logic [DW-1:0]     wdata;
    logic [1:0]        prv;
    logic [1:0]        rtype;
    logic [DW-1:0]     rdata;
    logic              err;

    modport master (
        output req, addr, wen, strb, wdata, prv, rtype,
        input  gnt, rdata, err
    );

    modport slave (
        input  req, addr, wen, strb, wdata, prv, rtype,
        output gnt, rdata, err
    );
endinterface

// File: rtl/ccx_ic_arbiter.sv
// Two-into-one core_mem_bus arbiter: fetch (imem) and load/store (dmem) share one routed port.
// Default is dmem priority with a starvation limit; define CCX_IC_ARB_RR_EN for round-robin instead.
module ccx_ic_arbiter #(
    parameter int AW           = 39,
    parameter int DW           = 64,
    parameter int STARVE_LIMIT = 4
) (
    input  logic         g_clk,
    input  logic         g_reset,
    core_mem_bus.slave   if_imem,
    core_mem_bus.slave   if_dmem,
    core_mem_bus.master  if_mem
);

    localparam logic SEL_IMEM = 1'b0;
    localparam logic SEL_DMEM = 1'b1;

    logic          sel;
    logic          lock;
    logic          rsp_vld;
    logic          rsp_own;
    logic          cur_sel;
    logic          xfer;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] rsp_rdata;

`ifdef CCX_IC_ARB_RR_EN
    logic          last_dmem;
`else
    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);
    logic [3:0]    starve_cnt;
`endif

    // Selection: a locked request keeps its port until granted.
    always_comb begin
        cur_sel = sel;
        if (!lock) begin
`ifdef CCX_IC_ARB_RR_EN
            if (if_imem.req && if_dmem.req)
                cur_sel = ~last_dmem;
            else if (if_dmem.req)
                cur_sel = SEL_DMEM;
            else if (if_imem.req)
                cur_sel = SEL_IMEM;
`else
            if (if_dmem.req && !(if_imem.req && starve_cnt == STARVE_MAX))
                cur_sel = SEL_DMEM;
            else if (if_imem.req)
                cur_sel = SEL_IMEM;
`endif
        end
    end

    assign req_addr     = (cur_sel == SEL_DMEM) ? if_dmem.addr : if_imem.addr;
    assign if_mem.addr  = req_addr;
    assign if_mem.req   = (cur_sel == SEL_DMEM) ? if_dmem.req   : if_imem.req;
    assign if_mem.wen   = (cur_sel == SEL_DMEM) ? if_dmem.wen   : if_imem.wen;
    assign if_mem.strb  = (cur_sel == SEL_DMEM) ? if_dmem.strb  : if_imem.strb;
    assign if_mem.wdata = (cur_sel == SEL_DMEM) ? if_dmem.wdata : if_imem.wdata;
    assign if_mem.prv   = (cur_sel == SEL_DMEM) ? if_dmem.prv   : if_imem.prv;
    assign if_mem.rtype = (cur_sel == SEL_DMEM) ? if_dmem.rtype : if_imem.rtype;

    assign xfer = if_mem.req && if_mem.gnt;

    // Grant reaches only the selected port, and only while it is actually requesting.
    assign if_imem.gnt = (cur_sel == SEL_IMEM) && if_imem.req && if_mem.gnt;
    assign if_dmem.gnt = (cur_sel == SEL_DMEM) && if_dmem.req && if_mem.gnt;

    assign rsp_rdata     = if_mem.rdata;
    assign if_imem.rdata = (rsp_vld && rsp_own == SEL_IMEM) ? rsp_rdata : '0;
    assign if_dmem.rdata = (rsp_vld && rsp_own == SEL_DMEM) ? rsp_rdata : '0;
    assign if_imem.err   = rsp_vld && (rsp_own == SEL_IMEM) && if_mem.err;
    assign if_dmem.err   = rsp_vld && (rsp_own == SEL_DMEM) && if_mem.err;

    always_ff @(posedge g_clk or posedge g_reset) begin
        if (g_reset) begin
            sel     <= SEL_IMEM;
            lock    <= 1'b0;
            rsp_vld <= 1'b0;
            rsp_own <= SEL_IMEM;
        end else begin
            sel     <= cur_sel;
            lock    <= if_mem.req && !if_mem.gnt;
            rsp_vld <= xfer;
            if (xfer)
                rsp_own <= cur_sel;
        end
    end

`ifdef CCX_IC_ARB_RR_EN
    // Resets to dmem so imem wins the first contested cycle.
    always_ff @(posedge g_clk or posedge g_reset) begin
        if (g_reset)
            last_dmem <= SEL_DMEM;
        else if (xfer)
            last_dmem <= cur_sel;
    end
`else
    // Counts dmem transfers that overtook a waiting imem; saturates, never wraps.
    always_ff @(posedge g_clk or posedge g_reset) begin
        if (g_reset)
            starve_cnt <= 4'd0;
        else if (!if_imem.req)
            starve_cnt <= 4'd0;
        else if (xfer && cur_sel == SEL_IMEM)
            starve_cnt <= 4'd0;
        else if (xfer && cur_sel == SEL_DMEM && starve_cnt != STARVE_MAX)
            starve_cnt <= starve_cnt + 4'd1;
    end
`endif

endmodule

// File: tb/tb_ccx_ic_arbiter.sv
// Directed bench for ccx_ic_arbiter: hand-computed expectations for issue order, grants and
// response steering, including lock hold, starvation pattern and reset mid-operation.
module tb_ccx_ic_arbiter;

    localparam int AW = 39;
    localparam int DW = 64;

    logic g_clk;
    logic g_reset;

    core_mem_bus #(.AW(AW), .DW(DW)) imem_bus ();
    core_mem_bus #(.AW(AW), .DW(DW)) dmem_bus ();
    core_mem_bus #(.AW(AW), .DW(DW)) mem_bus ();

    ccx_ic_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(4)) dut (
        .g_clk   (g_clk),
        .g_reset (g_reset),
        .if_imem (imem_bus),
        .if_dmem (dmem_bus),
        .if_mem  (mem_bus)
    );

    initial g_clk = 1'b0;
    always #5 g_clk = ~g_clk;

    int nvec = 0;
    int nerr = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic next_cyc();
        @(posedge g_clk);
        #1;
    endtask

    task automatic settle();
        @(negedge g_clk);
    endtask

    initial begin
        g_reset        = 1'b1;
        imem_bus.req   = 1'b0; imem_bus.addr = '0; imem_bus.wen = 1'b0;
        imem_bus.strb  = '0;   imem_bus.wdata = '0; imem_bus.prv = 2'd0; imem_bus.rtype = 2'd0;
        dmem_bus.req   = 1'b0; dmem_bus.addr = '0; dmem_bus.wen = 1'b0;
        dmem_bus.strb  = '0;   dmem_bus.wdata = '0; dmem_bus.prv = 2'd0; dmem_bus.rtype = 2'd0;
        mem_bus.gnt    = 1'b1;
        mem_bus.rdata  = 64'hFFFF_FFFF_FFFF_FFFF;
        mem_bus.err    = 1'b1;

        // Reset state, idle ports never see gnt even with the router granting.
        settle();
        chk("rst_mem_req",    64'(mem_bus.req), 64'd0);
        chk("rst_imem_gnt",   64'(imem_bus.gnt), 64'd0);
        chk("rst_dmem_gnt",   64'(dmem_bus.gnt), 64'd0);
        chk("rst_imem_rdata", imem_bus.rdata, 64'd0);
        chk("rst_dmem_err",   64'(dmem_bus.err), 64'd0);

        // Single imem read.
        next_cyc();
        g_reset = 1'b0;
        mem_bus.err = 1'b0;
        imem_bus.req = 1'b1; imem_bus.addr = 39'h100;
        settle();
        chk("t1_mem_req",   64'(mem_bus.req), 64'd1);
        chk("t1_mem_addr",  64'(mem_bus.addr), 64'h100);
        chk("t1_imem_gnt",  64'(imem_bus.gnt), 64'd1);
        chk("t1_dmem_gnt",  64'(dmem_bus.gnt), 64'd0);
        next_cyc();
        imem_bus.req = 1'b0;
        mem_bus.rdata = 64'hDEAD_BEEF;
        settle();
        chk("t1_imem_rdata", imem_bus.rdata, 64'hDEAD_BEEF);
        chk("t1_dmem_rdata", dmem_bus.rdata, 64'd0);
        chk("t1_idle_req",   64'(mem_bus.req), 64'd0);

        // Simultaneous requests: dmem first, then imem, responses steered in order.
        next_cyc();
        imem_bus.req = 1'b1; imem_bus.addr = 39'h200;
        dmem_bus.req = 1'b1; dmem_bus.addr = 39'h300; dmem_bus.wen = 1'b1;
        settle();
        chk("t2_first_addr", 64'(mem_bus.addr), 64'h300);
        chk("t2_first_wen",  64'(mem_bus.wen), 64'd1);
        chk("t2_dmem_gnt",   64'(dmem_bus.gnt), 64'd1);
        chk("t2_imem_nogn",  64'(imem_bus.gnt), 64'd0);
        next_cyc();
        dmem_bus.req = 1'b0; dmem_bus.wen = 1'b0;
        mem_bus.rdata = 64'h1111;
        settle();
        chk("t2_second_addr", 64'(mem_bus.addr), 64'h200);
        chk("t2_imem_gnt",    64'(imem_bus.gnt), 64'd1);
        chk("t2_dmem_rdata",  dmem_bus.rdata, 64'h1111);
        chk("t2_imem_rd0",    imem_bus.rdata, 64'd0);
        next_cyc();
        imem_bus.req = 1'b0;
        mem_bus.rdata = 64'h2222;
        settle();
        chk("t2_imem_rdata", imem_bus.rdata, 64'h2222);
        chk("t2_dmem_rd0",   dmem_bus.rdata, 64'd0);

        // Held imem request without grant stays selected while dmem arrives.
        next_cyc();
        mem_bus.gnt = 1'b0;
        imem_bus.req = 1'b1; imem_bus.addr = 39'h400;
        settle();
        chk("t3_c1_addr", 64'(mem_bus.addr), 64'h400);
        chk("t3_c1_gnt",  64'(imem_bus.gnt), 64'd0);
        for (int c = 2; c <= 3; c++) begin
            next_cyc();
            dmem_bus.req = 1'b1; dmem_bus.addr = 39'h500;
            settle();
            chk($sformatf("t3_c%0d_addr", c), 64'(mem_bus.addr), 64'h400);
            chk($sformatf("t3_c%0d_dgnt", c), 64'(dmem_bus.gnt), 64'd0);
        end
        next_cyc();
        mem_bus.gnt = 1'b1;
        settle();
        chk("t3_imem_gnt", 64'(imem_bus.gnt), 64'd1);
        chk("t3_dmem_ngn", 64'(dmem_bus.gnt), 64'd0);
        next_cyc();
        imem_bus.req = 1'b0;
        mem_bus.rdata = 64'h3333;
        settle();
        chk("t3_dmem_gnt",   64'(dmem_bus.gnt), 64'd1);
        chk("t3_dmem_addr",  64'(mem_bus.addr), 64'h500);
        chk("t3_imem_rdata", imem_bus.rdata, 64'h3333);

        // Continuous contention: 4 dmem then 1 imem (round-robin: alternate, imem first).
        next_cyc();
        imem_bus.req = 1'b1;
        dmem_bus.req = 1'b1;
        settle();
        for (int i = 0; i < 10; i++) begin
            logic exp_d;
            if (i > 0) begin
                next_cyc();
                settle();
            end
`ifdef CCX_IC_ARB_RR_EN
            exp_d = (i % 2) == 1;
`else
            exp_d = (i % 5) != 4;
`endif
            chk($sformatf("t4_dgnt_%0d", i), 64'(dmem_bus.gnt), 64'(exp_d));
            chk($sformatf("t4_ignt_%0d", i), 64'(imem_bus.gnt), 64'(!exp_d));
            chk($sformatf("t4_addr_%0d", i), 64'(mem_bus.addr), exp_d ? 64'h500 : 64'h400);
        end

        // Error response steered to the dmem store only.
        next_cyc();
        imem_bus.req = 1'b0;
        dmem_bus.req = 1'b0;
        next_cyc();
        dmem_bus.req = 1'b1; dmem_bus.addr = 39'h900; dmem_bus.wen = 1'b1;
        settle();
        chk("t5_dmem_gnt", 64'(dmem_bus.gnt), 64'd1);
        next_cyc();
        dmem_bus.req = 1'b0; dmem_bus.wen = 1'b0;
        mem_bus.rdata = 64'd0;
        mem_bus.err = 1'b1;
        settle();
        chk("t5_dmem_err", 64'(dmem_bus.err), 64'd1);
        chk("t5_imem_err", 64'(imem_bus.err), 64'd0);

        // Reset while a dmem response is in flight discards it immediately.
        next_cyc();
        mem_bus.err = 1'b0;
        dmem_bus.req = 1'b1; dmem_bus.addr = 39'h700;
        settle();
        chk("t6_dmem_gnt", 64'(dmem_bus.gnt), 64'd1);
        next_cyc();
        dmem_bus.addr = 39'h710;
        mem_bus.gnt = 1'b0;
        mem_bus.rdata = 64'hABC;
        mem_bus.err = 1'b1;
        #1;
        chk("t6_pre_rdata", dmem_bus.rdata, 64'hABC);
        g_reset = 1'b1;
        #1;
        chk("t6_rst_drdata", dmem_bus.rdata, 64'd0);
        chk("t6_rst_derr",   64'(dmem_bus.err), 64'd0);
        chk("t6_rst_ierr",   64'(imem_bus.err), 64'd0);
        chk("t6_rst_irdata", imem_bus.rdata, 64'd0);

        // Lock onto dmem, then reset: lock must be gone so imem issues right away.
        next_cyc();
        g_reset = 1'b0;
        mem_bus.err = 1'b0;
        next_cyc();
        g_reset = 1'b1;
        dmem_bus.req = 1'b0;
        imem_bus.req = 1'b1; imem_bus.addr = 39'h800;
        mem_bus.gnt = 1'b1;
        #1;
        chk("t6_lock_req",  64'(mem_bus.req), 64'd1);
        chk("t6_lock_addr", 64'(mem_bus.addr), 64'h800);
        next_cyc();
        g_reset = 1'b0;
        settle();
        chk("t6_post_req",  64'(mem_bus.req), 64'd1);
        chk("t6_post_addr", 64'(mem_bus.addr), 64'h800);
        chk("t6_post_gnt",  64'(imem_bus.gnt), 64'd1);
        next_cyc();
        imem_bus.req = 1'b0;
        mem_bus.rdata = 64'h55;
        settle();
        chk("t6_post_rdata", imem_bus.rdata, 64'h55);
        chk("t6_post_drd0",  dmem_bus.rdata, 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
